// File: rtl/display_pkg.sv
// display_pkg: shared segment glyphs, blanking constants and scan index type
package display_pkg;
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [3:0] DIGIT_OFF = 4'hF;
  typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} scan_idx_t;
endpackage

// File: rtl/bcd_to_7seg.sv
// bcd_to_7seg: BCD nibble to active-low {g,f,e,d,c,b,a}, dash for 10-15
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/display_scan_7seg.sv
// display_scan_7seg: 4-digit multiplexed 7-segment scanner with snapshot, zero blanking and blink
module display_scan_7seg
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 250
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic        blink,
  input  logic [15:0] digits_bcd,
  output logic [6:0]  seg,
  output logic [3:0]  digit_sel,
  output logic        frame_done
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [PW-1:0] presc;
  logic [BW-1:0] bcnt;
  scan_idx_t     idx, idx_n;
  logic          phase, phase_n, started, tick, wrap_b, lz, dark;
  logic [15:0]   snap, snap_n;
  logic [3:0]    nib;
  logic [6:0]    dec;
  bcd_to_7seg u_dec (.bcd(nib), .seg(dec));
  always_comb begin
    tick    = enable && presc == PW'(REFRESH_DIV - 1);
    wrap_b  = bcnt == BW'(BLINK_DIV - 1);
    idx_n   = tick ? scan_idx_t'(idx + 2'd1) : idx;
    phase_n = blink && ((tick && wrap_b) ? !phase : phase);
    snap_n  = (tick && (idx == DIG3 || !started)) ? digits_bcd : snap;
    nib     = snap_n[{idx_n, 2'b00} +: 4];
    lz      = blank_lz && idx_n != DIG0 && (snap_n >> {idx_n, 2'b00}) == 16'd0;
    dark    = !enable || !(started || tick);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      presc      <= '0;
      bcnt       <= '0;
      idx        <= DIG0;
      phase      <= 1'b0;
      started    <= 1'b0;
      snap       <= '0;
      seg        <= SEG_OFF;
      digit_sel  <= DIGIT_OFF;
      frame_done <= 1'b0;
    end else begin
      presc      <= !enable ? presc : tick ? '0 : presc + 1'b1;
      bcnt       <= !blink ? '0 : !tick ? bcnt : wrap_b ? '0 : bcnt + 1'b1;
      idx        <= idx_n;
      phase      <= phase_n;
      started    <= started || tick;
      snap       <= snap_n;
      seg        <= (dark || lz) ? SEG_OFF : dec;
      digit_sel  <= (dark || lz || (blink && phase_n)) ? DIGIT_OFF : ~(4'b0001 << idx_n);
      frame_done <= tick && idx_n == DIG0;
    end
  end
endmodule

// File: tb/tb_display_scan_7seg.sv
// tb_display_scan_7seg: scoreboard bench with hand-computed scan expectations
module tb_display_scan_7seg;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        blank_lz = 1'b0;
  logic        blink = 1'b0;
  logic [15:0] digits_bcd = 16'h1234;
  logic [6:0]  seg;
  logic [3:0]  digit_sel;
  logic        frame_done;
  typedef struct packed {
    logic [6:0] s;
    logic [3:0] d;
    logic       f;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  display_scan_7seg #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clock(clock), .reset(reset), .enable(enable), .blank_lz(blank_lz), .blink(blink),
    .digits_bcd(digits_bcd), .seg(seg), .digit_sel(digit_sel), .frame_done(frame_done)
  );
  task automatic cyc(input logic [6:0] s, input logic [3:0] d, input logic f);
    @(posedge clock);
    #1;
    exp_q.push_back({s, d, f});
  endtask
  task automatic slot(input logic [6:0] s, input logic [3:0] d, input logic f);
    cyc(s, d, f);
    repeat (3) cyc(s, d, 1'b0);
  endtask
  task automatic dark(input int n);
    repeat (n) cyc(7'h7F, 4'hF, 1'b0);
  endtask
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({seg, digit_sel, frame_done} !== e) begin
        errors++;
        $display("FAIL scan_out #%0d t=%0t: got seg=%h sel=%h fd=%b, want seg=%h sel=%h fd=%b",
                 checks, $time, seg, digit_sel, frame_done, e.s, e.d, e.f);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin
    cyc(7'h7F, 4'hF, 1'b0);
    reset = 1'b0;
    dark(3);
    slot(7'h30, 4'hD, 1'b0);
    slot(7'h24, 4'hB, 1'b0);
    slot(7'h79, 4'h7, 1'b0);
    slot(7'h19, 4'hE, 1'b1);
    slot(7'h30, 4'hD, 1'b0);
    digits_bcd = 16'h0070;
    blank_lz = 1'b1;
    slot(7'h24, 4'hB, 1'b0);
    slot(7'h79, 4'h7, 1'b0);
    slot(7'h40, 4'hE, 1'b1);
    slot(7'h78, 4'hD, 1'b0);
    digits_bcd = 16'h0100;
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h40, 4'hE, 1'b1);
    slot(7'h40, 4'hD, 1'b0);
    digits_bcd = 16'h0099;
    slot(7'h79, 4'hB, 1'b0);
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h10, 4'hE, 1'b1);
    slot(7'h10, 4'hD, 1'b0);
    digits_bcd = 16'h0B05;
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h7F, 4'hF, 1'b0);
    slot(7'h12, 4'hE, 1'b1);
    slot(7'h40, 4'hD, 1'b0);
    slot(7'h3F, 4'hB, 1'b0);
    slot(7'h7F, 4'hF, 1'b0);
    digits_bcd = 16'h4321;
    blank_lz = 1'b0;
    blink = 1'b1;
    repeat (2) begin
      slot(7'h79, 4'hE, 1'b1);
      slot(7'h24, 4'hF, 1'b0);
      slot(7'h30, 4'hF, 1'b0);
      slot(7'h19, 4'h7, 1'b0);
    end
    blink = 1'b0;
    slot(7'h79, 4'hE, 1'b1);
    repeat (2) cyc(7'h24, 4'hD, 1'b0);
    enable = 1'b0;
    dark(6);
    enable = 1'b1;
    repeat (2) cyc(7'h24, 4'hD, 1'b0);
    slot(7'h30, 4'hB, 1'b0);
    slot(7'h19, 4'h7, 1'b0);
    slot(7'h79, 4'hE, 1'b1);
    slot(7'h24, 4'hD, 1'b0);
    repeat (2) cyc(7'h30, 4'hB, 1'b0);
    reset = 1'b1;
    cyc(7'h7F, 4'hF, 1'b0);
    reset = 1'b0;
    dark(3);
    slot(7'h24, 4'hD, 1'b0);
    slot(7'h30, 4'hB, 1'b0);
    slot(7'h19, 4'h7, 1'b0);
    slot(7'h79, 4'hE, 1'b1);
    repeat (2) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
